// File: rtl/pop_data_pkg.sv
// Shared constants for the pop_data byte-pair reassembler.
// FSM encodings and frame-error cause codes.
package pop_data_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_GAP     = 2'b01;
    localparam logic [1:0] ST_WAIT_HI = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_GAP     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_BAD_HI  = 2'b11;

endpackage

// File: rtl/pop_data.sv
// Reassembles a speed word from a low byte, an idle gap and a high byte.
// Flags gap violations, high-byte timeouts and nonzero unused high bits.
module pop_data
    import pop_data_pkg::*;
#(
    parameter int WIDTH_SPEED = 14,
    parameter int DATA_SIZE   = 8,
    parameter int TIMEOUT     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write,
    input  logic [DATA_SIZE-1:0]   data,
    output logic [WIDTH_SPEED-1:0] speed,
    output logic                   valid,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic                   busy
);

    localparam int HI_W = WIDTH_SPEED - DATA_SIZE;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    // Bits of the high byte that fall above the speed word; must arrive as zero.
    localparam logic [DATA_SIZE-1:0] UNUSED_MASK = {DATA_SIZE{1'b1}} << HI_W;

    logic [1:0]           state;
    logic [TW-1:0]        timer;
    logic [DATA_SIZE-1:0] low_byte;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            low_byte <= '0;
            speed    <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            valid    <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            case (state)
                ST_IDLE: begin
                    if (write) begin
                        low_byte <= data;
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (write) begin
                        // Back-to-back bytes: resync on the newest one as the low byte.
                        low_byte <= data;
                        err      <= 1'b1;
                        err_code <= ERR_GAP;
                    end else begin
                        state <= ST_WAIT_HI;
                        timer <= '0;
                    end
                end
                ST_WAIT_HI: begin
                    if (write) begin
                        state <= ST_IDLE;
                        timer <= '0;
                        if ((data & UNUSED_MASK) == '0) begin
                            speed <= {data[HI_W-1:0], low_byte};
                            valid <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_BAD_HI;
                        end
                    end else if (timer == TLAST) begin
                        state    <= ST_IDLE;
                        timer    <= '0;
                        low_byte <= '0;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pop_data.sv
// Directed bench for pop_data with hand-computed expectations (default parameters).
module tb_pop_data;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [7:0]  data;
    logic [13:0] speed;
    logic        valid;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    int checks = 0;
    int errors = 0;

    pop_data #(.WIDTH_SPEED(14), .DATA_SIZE(8), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .write(write), .data(data),
        .speed(speed), .valid(valid), .err(err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of input; returns #1 after the edge that consumed it.
    task automatic cyc(input logic w, input logic [7:0] d);
        write = w;
        data  = d;
        @(posedge clk);
        #1;
        chk("excl", {15'd0, valid & err}, 16'd0);
    endtask

    initial begin
        reset = 1'b1;
        write = 1'b0;
        data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_speed", {2'b0, speed}, 16'h0000);
        chk("rst_valid", {15'd0, valid}, 16'd0);
        chk("rst_err",   {15'd0, err}, 16'd0);
        chk("rst_code",  {14'd0, err_code}, 16'd0);
        chk("rst_busy",  {15'd0, busy}, 16'd0);
        reset = 1'b0;

        // Basic frame
        cyc(1'b1, 8'h5B);
        chk("f1_busy", {15'd0, busy}, 16'd1);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h2A);
        chk("f1_valid", {15'd0, valid}, 16'd1);
        chk("f1_speed", {2'b0, speed}, 16'h2A5B);
        chk("f1_err",   {15'd0, err}, 16'd0);
        chk("f1_busy0", {15'd0, busy}, 16'd0);
        cyc(1'b0, 8'h00);
        chk("f1_pulse", {15'd0, valid}, 16'd0);
        chk("f1_hold",  {2'b0, speed}, 16'h2A5B);

        // Bad high byte
        cyc(1'b1, 8'h5B);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'hC1);
        chk("bad_err",   {15'd0, err}, 16'd1);
        chk("bad_code",  {14'd0, err_code}, 16'h3);
        chk("bad_valid", {15'd0, valid}, 16'd0);
        chk("bad_speed", {2'b0, speed}, 16'h2A5B);
        cyc(1'b0, 8'h00);
        chk("bad_clr",   {14'd0, err_code}, 16'h0);

        // Timeout after 4 idle WAIT_HI cycles
        cyc(1'b1, 8'h10);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        chk("to_pre_err",  {15'd0, err}, 16'd0);
        chk("to_pre_busy", {15'd0, busy}, 16'd1);
        cyc(1'b0, 8'h00);
        chk("to_err",  {15'd0, err}, 16'd1);
        chk("to_code", {14'd0, err_code}, 16'h2);
        chk("to_busy", {15'd0, busy}, 16'd0);
        cyc(1'b1, 8'h34);
        chk("to_nxt_err", {15'd0, err}, 16'd0);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h01);
        chk("to_nxt_valid", {15'd0, valid}, 16'd1);
        chk("to_nxt_speed", {2'b0, speed}, 16'h0134);

        // Gap violation resync
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22);
        chk("gap_err",  {15'd0, err}, 16'd1);
        chk("gap_code", {14'd0, err_code}, 16'h1);
        chk("gap_busy", {15'd0, busy}, 16'd1);
        cyc(1'b0, 8'h00);
        chk("gap_pulse", {15'd0, err}, 16'd0);
        cyc(1'b1, 8'h03);
        chk("gap_valid", {15'd0, valid}, 16'd1);
        chk("gap_speed", {2'b0, speed}, 16'h0322);

        // Reset during GAP
        cyc(1'b1, 8'h77);
        write = 1'b0;
        reset = 1'b1;
        #1;
        chk("mr_speed", {2'b0, speed}, 16'h0000);
        chk("mr_busy",  {15'd0, busy}, 16'd0);
        @(posedge clk);
        #1;
        chk("mr_err",   {15'd0, err}, 16'd0);
        chk("mr_code",  {14'd0, err_code}, 16'd0);
        chk("mr_valid", {15'd0, valid}, 16'd0);
        reset = 1'b0;
        cyc(1'b1, 8'hFF);
        chk("mr_low_busy", {15'd0, busy}, 16'd1);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h3F);
        chk("mr_valid2", {15'd0, valid}, 16'd1);
        chk("mr_speed2", {2'b0, speed}, 16'h3FFF);

        // High byte on the last WAIT_HI cycle wins over timeout
        cyc(1'b1, 8'h55);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h12);
        chk("edge_valid", {15'd0, valid}, 16'd1);
        chk("edge_err",   {15'd0, err}, 16'd0);
        chk("edge_speed", {2'b0, speed}, 16'h1255);
        cyc(1'b0, 8'h00);
        chk("edge_noto", {15'd0, err}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pop_data.md
POP_DATA -- requirements
Module: pop_data

Interface
REQ-001 The block SHALL have parameter WIDTH_SPEED, default 14, giving the width of the reassembled speed word.
REQ-002 The block SHALL have parameter DATA_SIZE, default 8, giving the byte-lane width; legal range DATA_SIZE < WIDTH_SPEED <= 2*DATA_SIZE.
REQ-003 The block SHALL have parameter TIMEOUT, default 4, giving the maximum number of WAIT_HI cycles (>=1) before the high byte is abandoned.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port write, input, 1 bit: byte strobe, one byte per high cycle.
REQ-007 The block SHALL have port data, input, DATA_SIZE bits: byte lane, sampled only when write=1.
REQ-008 The block SHALL have port speed, output, WIDTH_SPEED bits: last successfully reassembled word, registered.
REQ-009 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking an update of speed.
REQ-010 The block SHALL have port err, output, 1 bit: one-cycle pulse on a frame error.
REQ-011 The block SHALL have port err_code, output, 2 bits: cause of err, 01 = gap violation, 10 = timeout, 11 = bad high byte, 00 otherwise.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a low byte is held (GAP or WAIT_HI).

Function
REQ-013 A frame SHALL consist of a low byte (speed[DATA_SIZE-1:0]), then at least one idle cycle, then a high byte whose lower WIDTH_SPEED-DATA_SIZE bits are speed[WIDTH_SPEED-1:DATA_SIZE].
REQ-014 The FSM SHALL have states IDLE, GAP and WAIT_HI.
REQ-015 In IDLE, write=1 SHALL capture data as the low byte, and the FSM SHALL then enter GAP.
REQ-016 In GAP, write=0 SHALL move the FSM to WAIT_HI with the timer cleared.
REQ-017 In GAP, write=1 SHALL pulse err with err_code=01, take data as the new low byte, and keep the FSM in GAP (resync).
REQ-018 In WAIT_HI, write=1 SHALL capture the high byte and return the FSM to IDLE.
REQ-019 On a high-byte capture whose unused upper bits data[DATA_SIZE-1:WIDTH_SPEED-DATA_SIZE] are zero, the block SHALL load speed and pulse valid in the next cycle.
REQ-020 On a high-byte capture with any nonzero unused upper bit, the block SHALL pulse err with err_code=11 and leave speed unchanged.
REQ-021 In WAIT_HI with write=0, the timer SHALL increment; when it reaches TIMEOUT-1 with write=0, the block SHALL pulse err with err_code=10 next cycle and return to IDLE, discarding the low byte.
REQ-022 When a write arrives in the same cycle the timeout would expire, the write SHALL win and no timeout SHALL be flagged.
REQ-023 Latency SHALL be exactly one cycle from the high-byte write cycle to valid/err.
REQ-024 valid and err SHALL never be high together.
REQ-025 err_code SHALL be 00 whenever err=0.
REQ-026 speed SHALL hold its value between valid pulses.
REQ-027 The block SHALL tolerate the two-cycle spacing (byte, idle, byte) produced by the team's existing byte-push transmitter.

Reset
REQ-028 While reset=1, the FSM SHALL be IDLE, and speed, valid, err, err_code, busy, the timer and the low-byte register SHALL all be 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame without any err pulse.
REQ-030 After reset deasserts, the next write SHALL be treated as a low byte.

Structure
REQ-031 State encodings (2 bits) and err_code constants SHALL live in the shared project package, with no new typedefs.
REQ-032 The block SHALL use no sub-module; the timer SHALL be an inline counter of width $clog2(TIMEOUT+1).

Verification
REQ-033 The bench SHALL check: write 0x5B, idle, write 0x2A -> one cycle later valid=1, speed=0x2A5B, err=0.
REQ-034 The bench SHALL check: write 0x5B, idle, write 0xC1 -> err=1, err_code=11, valid=0, speed keeps its prior value.
REQ-035 The bench SHALL check: write 0x10, then 4 idle cycles in WAIT_HI -> err=1, err_code=10, busy=0; a following frame 0x34/0x01 -> speed=0x0134.
REQ-036 The bench SHALL check: write 0x11, write 0x22 back-to-back, idle, write 0x03 -> err pulse with code 01, then valid with speed=0x0322.
REQ-037 The bench SHALL check: write 0x77, reset pulsed during GAP -> all outputs 0 and no err; the next frame 0xFF/0x3F -> speed=0x3FFF.
REQ-038 The bench SHALL check: high-byte write in the final WAIT_HI cycle (TIMEOUT=4) -> valid asserted and no timeout err.
